// File: rtl/fft_arb_pkg.sv
// Shared types and defaults for the FFT frame arbiter: FSM state encoding,
// size defaults and the requester-id width helper.
package fft_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_PAD    = 2'd2
    } arb_state_e;

    localparam int FRAME_LEN_DEF = 16;
    localparam int DW_DEF        = 16;

    // A single requester still needs a 1-bit id field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fft_tag_fifo.sv
// Synchronous tag FIFO recording which requester owns each frame inside the FFT.
// Simultaneous push and pop both take effect, including push while full.
module fft_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        do_pop  = pop && (cnt_q != '0);
        do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);
        if (do_push) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
        if (do_pop)  rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/fft_frame_arbiter.sv
// Shares one FFT core between NREQ streaming requesters, one whole frame per grant,
// and labels returning FFT frames with owner id. Macro FFT_ARB_WATCHDOG_EN adds a stall watchdog.
module fft_frame_arbiter
    import fft_arb_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int DW        = DW_DEF,
    parameter int TAG_DEPTH = 4
`ifdef FFT_ARB_WATCHDOG_EN
    , parameter int WD_CYCLES = 64
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_push,
    input  logic [NREQ*DW-1:0]          req_real,
    input  logic [NREQ*DW-1:0]          req_imag,
    output logic [NREQ-1:0]             req_stall,
    output logic                        fft_push,
    output logic [DW-1:0]               fft_real,
    output logic [DW-1:0]               fft_imag,
    input  logic                        fft_stall,
    input  logic                        fft_out_push,
    input  logic [DW-1:0]               fft_out_real,
    input  logic [DW-1:0]               fft_out_imag,
    output logic                        fft_out_stall,
    output logic                        out_push,
    output logic [DW-1:0]               out_real,
    output logic [DW-1:0]               out_imag,
    output logic [id_width(NREQ)-1:0]   out_id,
    output logic                        out_last,
    input  logic                        out_stall,
    output logic                        busy,
`ifdef FFT_ARB_WATCHDOG_EN
    output logic                        err_timeout,
`endif
    output logic                        err_orphan
);

    localparam int ID_W = id_width(NREQ);
    localparam int SC_W = $clog2(FRAME_LEN);
    localparam int TC_W = $clog2(TAG_DEPTH + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(FRAME_LEN - 1);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d, last_grant_q, last_grant_d;
    logic [SC_W-1:0] scnt_q, scnt_d, ocnt_q, ocnt_d;
    logic            err_orphan_q, err_orphan_d;

    logic            tag_push, tag_pop, tag_full, tag_empty;
    logic [ID_W-1:0] tag_head;
    logic [TC_W-1:0] tag_count;

    logic            pick_found;
    logic [ID_W-1:0] pick;
    logic            sel_push;
    logic [DW-1:0]   sel_real, sel_imag;
    logic            out_acc;

`ifdef FFT_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);
    logic [WD_W-1:0] idle_q, idle_d;
    logic            err_timeout_q, err_timeout_d;
`endif

    // Round-robin: first pushing requester strictly after last_grant, then wrap around.
    always_comb begin
        pick_found = 1'b0;
        pick       = last_grant_q;
        for (int i = 0; i < NREQ; i++) begin
            if (!pick_found && req_push[i] && (i > int'(last_grant_q))) begin
                pick_found = 1'b1;
                pick       = ID_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!pick_found && req_push[i] && (i <= int'(last_grant_q))) begin
                pick_found = 1'b1;
                pick       = ID_W'(i);
            end
        end
    end

    always_comb begin
        sel_push = 1'b0;
        sel_real = '0;
        sel_imag = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == ID_W'(i)) begin
                sel_push = req_push[i];
                sel_real = req_real[i*DW +: DW];
                sel_imag = req_imag[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        scnt_d       = scnt_q;
        req_stall    = '1;
        fft_push     = 1'b0;
        fft_real     = '0;
        fft_imag     = '0;
        tag_push     = 1'b0;
`ifdef FFT_ARB_WATCHDOG_EN
        idle_d        = idle_q;
        err_timeout_d = err_timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_found && !tag_full) begin
                    grant_d = pick;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                fft_push = sel_push;
                fft_real = sel_real;
                fft_imag = sel_imag;
                for (int i = 0; i < NREQ; i++) begin
                    if (grant_q == ID_W'(i)) req_stall[i] = fft_stall;
                end
                if (sel_push && !fft_stall) begin
                    scnt_d = scnt_q + 1'b1;
`ifdef FFT_ARB_WATCHDOG_EN
                    idle_d = '0;
`endif
                    if (scnt_q == SC_LAST) begin
                        tag_push     = 1'b1;
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end
                end
`ifdef FFT_ARB_WATCHDOG_EN
                else if (!sel_push) begin
                    if (idle_q == WD_W'(WD_CYCLES - 1)) begin
                        idle_d        = '0;
                        err_timeout_d = 1'b1;
                        state_d       = ST_PAD;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
`endif
            end
`ifdef FFT_ARB_WATCHDOG_EN
            // Finish the abandoned frame with zero samples so the FFT stays frame-aligned.
            ST_PAD: begin
                fft_push = 1'b1;
                if (!fft_stall) begin
                    scnt_d = scnt_q + 1'b1;
                    if (scnt_q == SC_LAST) begin
                        tag_push     = 1'b1;
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Output samples are only labelled while a tag is present; orphans are swallowed.
    always_comb begin
        out_push      = fft_out_push && !tag_empty;
        fft_out_stall = out_stall && !tag_empty;
        out_real      = fft_out_real;
        out_imag      = fft_out_imag;
        out_id        = tag_head;
        out_last      = (ocnt_q == SC_LAST);
        out_acc       = out_push && !out_stall;
        tag_pop       = out_acc && out_last;
        ocnt_d        = out_acc ? ocnt_q + 1'b1 : ocnt_q;
        err_orphan_d  = err_orphan_q || (fft_out_push && tag_empty);
        busy          = (state_q != ST_IDLE) || (tag_count != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_W'(NREQ - 1);
            scnt_q       <= '0;
            ocnt_q       <= '0;
            err_orphan_q <= 1'b0;
`ifdef FFT_ARB_WATCHDOG_EN
            idle_q        <= '0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            scnt_q       <= scnt_d;
            ocnt_q       <= ocnt_d;
            err_orphan_q <= err_orphan_d;
`ifdef FFT_ARB_WATCHDOG_EN
            idle_q        <= idle_d;
            err_timeout_q <= err_timeout_d;
`endif
        end
    end

    fft_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (ID_W)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tag_push),
        .din   (grant_q),
        .pop   (tag_pop),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    assign err_orphan = err_orphan_q;
`ifdef FFT_ARB_WATCHDOG_EN
    assign err_timeout = err_timeout_q;
`endif

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Scoreboard bench for fft_frame_arbiter: bench requesters, a loopback FFT model,
// and input/output monitors popping expected samples pushed by the directed tests.
module tb_fft_frame_arbiter;
    import fft_arb_pkg::*;

    localparam int NREQ = 2;
    localparam int FL   = 16;
    localparam int DW   = 16;
    localparam int IDW  = id_width(NREQ);

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } samp_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           last;
        logic [DW-1:0]  re;
        logic [DW-1:0]  im;
    } osamp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_push, req_stall;
    logic [NREQ*DW-1:0]   req_real, req_imag;
    logic                 fft_push, fft_stall, fft_out_push, fft_out_stall;
    logic [DW-1:0]        fft_real, fft_imag, fft_out_real, fft_out_imag;
    logic                 out_push, out_last, out_stall, busy, err_orphan;
    logic [DW-1:0]        out_real, out_imag;
    logic [IDW-1:0]       out_id;
`ifdef FFT_ARB_WATCHDOG_EN
    logic                 err_timeout;
`endif

    samp_t  exp_in_q[$];
    osamp_t exp_out_q[$];
    samp_t  lb_q[$];
    int     rem[NREQ]    = '{default: 0};
    int     seq[NREQ]    = '{default: 0};
    int     ex_seq[NREQ] = '{default: 0};
    int     lb_oc        = 0;
    logic   lb_valid     = 1'b0;
    logic   orphan_r     = 1'b0;
    int     chk_cnt      = 0;
    int     pass_cnt     = 0;

    always #5 clk = ~clk;

    assign fft_out_push = lb_valid | orphan_r;

    fft_frame_arbiter #(
        .NREQ      (NREQ),
        .FRAME_LEN (FL),
        .DW        (DW),
        .TAG_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_push      (req_push),
        .req_real      (req_real),
        .req_imag      (req_imag),
        .req_stall     (req_stall),
        .fft_push      (fft_push),
        .fft_real      (fft_real),
        .fft_imag      (fft_imag),
        .fft_stall     (fft_stall),
        .fft_out_push  (fft_out_push),
        .fft_out_real  (fft_out_real),
        .fft_out_imag  (fft_out_imag),
        .fft_out_stall (fft_out_stall),
        .out_push      (out_push),
        .out_real      (out_real),
        .out_imag      (out_imag),
        .out_id        (out_id),
        .out_last      (out_last),
        .out_stall     (out_stall),
        .busy          (busy),
`ifdef FFT_ARB_WATCHDOG_EN
        .err_timeout   (err_timeout),
`endif
        .err_orphan    (err_orphan)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Sample payload encodes owner in the top nibble and a per-requester sequence number.
    function automatic samp_t mk(input int id, input int n);
        samp_t s;
        s.re = {4'(id), 12'(n)};
        s.im = ~s.re;
        return s;
    endfunction

    task automatic expect_samp(input int id, input samp_t s, input logic last);
        osamp_t o;
        o.id   = IDW'(id);
        o.last = last;
        o.re   = s.re;
        o.im   = s.im;
        exp_in_q.push_back(s);
        exp_out_q.push_back(o);
    endtask

    task automatic expect_frame(input int id);
        for (int k = 0; k < FL; k++) expect_samp(id, mk(id, ex_seq[id] + k), k == FL - 1);
        ex_seq[id] += FL;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while ((exp_in_q.size() != 0 || exp_out_q.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_drained"}, 64'(exp_in_q.size() + exp_out_q.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 0; seq[i] = 0; ex_seq[i] = 0;
        end
        exp_in_q.delete();
        exp_out_q.delete();
        lb_q.delete();
        lb_oc     = 0;
        fft_stall = 1'b0;
        out_stall = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
    endtask

    // Requesters: each offers rem[i] samples, advancing on accepted transfers.
    initial begin : driver
        logic [NREQ-1:0] acc;
        req_push = '0;
        req_real = '0;
        req_imag = '0;
        forever begin
            @(negedge clk);
            acc = req_push & ~req_stall;
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                samp_t s;
                if (acc[i] && !reset) begin
                    seq[i]++;
                    rem[i]--;
                end
                s = mk(i, seq[i]);
                req_push[i] = (rem[i] > 0);
                req_real[i*DW +: DW] = s.re;
                req_imag[i*DW +: DW] = s.im;
            end
        end
    end

    // Identity FFT: replays each captured frame once it is complete.
    initial begin : fft_model
        logic  in_acc, o_acc;
        samp_t in_s;
        fft_out_real = '0;
        fft_out_imag = '0;
        forever begin
            @(negedge clk);
            in_acc  = fft_push && !fft_stall;
            in_s.re = fft_real;
            in_s.im = fft_imag;
            o_acc   = fft_out_push && !fft_out_stall;
            @(posedge clk); #1;
            if (!reset && in_acc) lb_q.push_back(in_s);
            if (!reset && o_acc && lb_q.size() > 0) begin
                lb_q.delete(0);
                lb_oc = (lb_oc + 1) % FL;
            end
            lb_valid = (lb_oc != 0 && lb_q.size() > 0) || (lb_q.size() >= FL);
            if (lb_q.size() > 0) begin
                fft_out_real = lb_q[0].re;
                fft_out_imag = lb_q[0].im;
            end else begin
                fft_out_real = '0;
                fft_out_imag = '0;
            end
        end
    end

    initial begin : mon_in
        forever begin
            @(negedge clk);
            if (!reset && fft_push && !fft_stall) begin
                logic [NREQ-1:0] own;
                own = NREQ'(1) << fft_real[DW-1 -: 4];
                check("other_req_stalled", 64'(req_stall | own), 64'({NREQ{1'b1}}));
                if (exp_in_q.size() == 0) begin
                    check("fft_in_unexpected", 64'({fft_real, fft_imag}), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    samp_t e;
                    e = exp_in_q.pop_front();
                    check("fft_in_sample", 64'({fft_real, fft_imag}), 64'(e));
                end
            end
        end
    end

    initial begin : mon_out
        forever begin
            @(negedge clk);
            if (!reset && out_push && !out_stall) begin
                if (exp_out_q.size() == 0) begin
                    check("out_unexpected", 64'({out_id, out_last, out_real, out_imag}), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    osamp_t e;
                    e = exp_out_q.pop_front();
                    check("out_sample", 64'({out_id, out_last, out_real, out_imag}), 64'(e));
                end
            end
        end
    end

    initial begin : timeout
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        reset     = 1'b1;
        fft_stall = 1'b0;
        out_stall = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_req_stall", 64'(req_stall), 64'({NREQ{1'b1}}));
        check("rst_fft_push", 64'(fft_push), 64'd0);
        check("rst_out_push", 64'(out_push), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err_orphan", 64'(err_orphan), 64'd0);

        // Orphan FFT output with no frame in flight.
        @(posedge clk); #2;
        orphan_r  = 1'b1;
        out_stall = 1'b1;
        @(negedge clk);
        check("orphan_out_push", 64'(out_push), 64'd0);
        check("orphan_consumed", 64'(fft_out_stall), 64'd0);
        check("orphan_not_yet", 64'(err_orphan), 64'd0);
        @(posedge clk); #2;
        orphan_r  = 1'b0;
        out_stall = 1'b0;
        @(negedge clk);
        check("orphan_set", 64'(err_orphan), 64'd1);
        repeat (3) @(negedge clk);
        check("orphan_sticky", 64'(err_orphan), 64'd1);
        do_reset();
        check("orphan_cleared", 64'(err_orphan), 64'd0);

        // Single requester, one frame, no stalls.
        @(posedge clk); #2;
        rem[0] = FL;
        expect_frame(0);
        @(negedge clk);
        @(negedge clk);
        check("t1_arb_no_push", 64'(fft_push), 64'd0);
        check("t1_arb_stall", 64'(req_stall), 64'({NREQ{1'b1}}));
        @(negedge clk);
        check("t1_first_push", 64'(fft_push), 64'd1);
        check("t1_busy", 64'(busy), 64'd1);
        n = 1;
        repeat (40) begin
            @(negedge clk);
            if (fft_push) n++;
        end
        check("t1_push_cycles", 64'(n), 64'(FL));
        wait_drain("t1", 200);
        check("t1_idle", 64'(busy), 64'd0);

        // Both requesters continuously: frames 0,1,0,1.
        do_reset();
        @(posedge clk); #2;
        rem[0] = 2 * FL;
        rem[1] = 2 * FL;
        expect_frame(0);
        expect_frame(1);
        expect_frame(0);
        expect_frame(1);
        wait_drain("t2", 400);

        // fft_stall for 3 cycles mid-frame.
        @(posedge clk); #2;
        rem[0] = FL;
        expect_frame(0);
        n = 0;
        while (!fft_push && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t3_started", 64'(fft_push), 64'd1);
        repeat (4) @(negedge clk);
        @(posedge clk); #2;
        fft_stall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t3_stall_mirror", 64'(req_stall[0]), 64'd1);
        end
        @(posedge clk); #2;
        fft_stall = 1'b0;
        @(negedge clk);
        check("t3_stall_release", 64'(req_stall[0]), 64'd0);
        wait_drain("t3", 200);

        // Tag FIFO full: four frames held at the output, fifth request must wait.
        @(posedge clk); #2;
        out_stall = 1'b1;
        rem[0]    = 4 * FL;
        for (int f = 0; f < 4; f++) expect_frame(0);
        n = 0;
        while (exp_in_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t4_four_frames_in", 64'(exp_in_q.size()), 64'd0);
        @(posedge clk); #2;
        rem[1] = FL;
        expect_frame(1);
        repeat (10) @(negedge clk);
        check("t4_full_stall", 64'(req_stall), 64'({NREQ{1'b1}}));
        check("t4_full_no_push", 64'(fft_push), 64'd0);
        check("t4_full_busy", 64'(busy), 64'd1);
        @(posedge clk); #2;
        out_stall = 1'b0;
        wait_drain("t4", 600);
        check("t4_idle", 64'(busy), 64'd0);

`ifdef FFT_ARB_WATCHDOG_EN
        // Requester 0 stops after 5 samples; frame is padded with zeros.
        @(posedge clk); #2;
        rem[0] = 5;
        for (int k = 0; k < 5; k++) expect_samp(0, mk(0, ex_seq[0] + k), 1'b0);
        for (int k = 5; k < FL; k++) expect_samp(0, samp_t'('0), k == FL - 1);
        ex_seq[0] += 5;
        wait_drain("t5_pad", 400);
        check("t5_err_timeout", 64'(err_timeout), 64'd1);
        @(posedge clk); #2;
        rem[1] = FL;
        expect_frame(1);
        wait_drain("t5_next", 200);
        check("t5_idle", 64'(busy), 64'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
